fifo_stream_reader: RTL

//   Read-side controller for the team's synchronous FIFO (registered read: data valid the cycle after rden & !empty).

---
 rtl/fifo_stream_reader_if.sv | 25 ++
 rtl/fifo_stream_reader.sv | 80 ++++++++
 2 files changed

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus output stream bundle for fifo_stream_reader.
// master = reader side, slave = FIFO/MAC environment.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 2
);
    logic             fifo_empty;
    logic             fifo_rden;
    logic [WIDTH-1:0] fifo_rddata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [IDX_W-1:0] out_idx;

    modport master (
        input  fifo_empty, fifo_rddata, out_ready,
        output fifo_rden, out_valid, out_data, out_last, out_idx
    );

    modport slave (
        output fifo_empty, fifo_rddata, out_ready,
        input  fifo_rden, out_valid, out_data, out_last, out_idx
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read sync FIFO into a framed valid/ready stream.
// Two-entry skid buffer keeps full throughput under backpressure.
module fifo_stream_reader #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 4,
    parameter int IDX_W     = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic flush,
    fifo_stream_reader_if.master bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [1:0]       cnt;
    logic             inflight;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             pop;
    logic             rden;
    logic [2:0]       occ;

    assign valid = (cnt != 2'd0);
    assign pop   = valid & bus.out_ready;

    // Occupancy after this edge, excluding a read issued now
    assign occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

    assign rden = rstn & en & ~flush & ~bus.fifo_empty
                & (occ <= 3'd1);

    assign bus.fifo_rden = rden;
    assign bus.out_valid = valid;
    assign bus.out_data  = head;
    assign bus.out_idx   = idx;
    assign bus.out_last  = valid & (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            idx      <= '0;
        end else if (flush) begin
            cnt      <= 2'd0;
            inflight <= 1'b0;
            idx      <= '0;
        end else begin
            inflight <= rden;
            if (pop) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            case ({pop, inflight})
                2'b10: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b01: begin
                    if (cnt == 2'd0) head <= bus.fifo_rddata;
                    else             tail <= bus.fifo_rddata;
                    cnt <= cnt + 2'd1;
                end
                2'b11: begin
                    // Pop and capture together: count stays put
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= bus.fifo_rddata;
                    end else begin
                        head <= bus.fifo_rddata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
